// File: rtl/chip_layer_responder.sv
// -----------------------------------------------------------------------------
// chip_layer_responder
//
// Stand-in for the chip side of the network controller link. Each start_layer
// pulse starts a compute whose length comes from a 64-entry programmable
// latency table, indexed by the running layer index. When the compute finishes,
// the block returns a single-cycle done_layer pulse. This lets the controller,
// host software and power-measure loops run without silicon.
//
// Optional feature macro: LOOPBACK_TEST_EN
//   defined   : start_store_byte4 starts a compute of fixed length STORE_LAT.
//   undefined : start_store_byte4 is ignored. The port is still present.
//
// Parameters
//   LAT_W      width of one latency table entry
//   STORE_LAT  compute length for a store request (LOOPBACK_TEST_EN only)
//
// Ports
//   chip_clk           clock, rising edge
//   rstn               asynchronous active-low reset
//   start_layer        layer start request (single-cycle pulse)
//   start_store_byte4  store request (LOOPBACK_TEST_EN only)
//   n_layers           layer count; sets the wrap point of layer_idx
//   cfg_we/addr/lat    latency table write port, usable in any state
//   done_layer         single-cycle completion pulse (registered)
//   busy               high while a compute is running
//   layer_idx          index of the next layer to run
//   overrun_err        sticky; a request arrived while busy
//   done_cnt           number of done_layer pulses since reset (wraps)
// -----------------------------------------------------------------------------
module chip_layer_responder #(
    parameter int LAT_W     = 16,
    parameter int STORE_LAT = 4
) (
    input  logic             chip_clk,
    input  logic             rstn,
    input  logic             start_layer,
    input  logic             start_store_byte4,
    input  logic [5:0]       n_layers,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic [LAT_W-1:0] cfg_lat,
    output logic             done_layer,
    output logic             busy,
    output logic [5:0]       layer_idx,
    output logic             overrun_err,
    output logic [31:0]      done_cnt
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COMPUTE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       layer_idx_q, layer_idx_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [31:0]      done_cnt_q, done_cnt_d;
    logic [LAT_W-1:0] lat_tbl_q [64];

    logic             req_store;
    logic [5:0]       idx_next;

`ifdef LOOPBACK_TEST_EN
    assign req_store = start_store_byte4;
`else
    logic unused_store;
    assign req_store    = 1'b0;
    assign unused_store = start_store_byte4;
`endif

    // A latency of 0 behaves like 1. The counter is loaded with L-1, so the
    // cnt == 0 cycle is the last cycle of the compute.
    function automatic logic [LAT_W-1:0] lat_to_cnt(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? '0 : lat - LAT_W'(1);
    endfunction

    // n_layers is used as it stands at the update edge. An index that is
    // already past n_layers-1 (n_layers lowered on the fly) keeps counting
    // up and wraps at 64.
    always_comb begin
        if (n_layers == 6'd0) begin
            idx_next = 6'd0;
        end else if (layer_idx_q == n_layers - 6'd1) begin
            idx_next = 6'd0;
        end else begin
            idx_next = layer_idx_q + 6'd1;
        end
    end

    // Latency table. Register semantics mean that a start on the same edge
    // as a write to the same entry reads the old value.
    always_ff @(posedge chip_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) begin
                lat_tbl_q[i] <= LAT_W'(1);
            end
        end else if (cfg_we) begin
            lat_tbl_q[cfg_addr] <= cfg_lat;
        end
    end

    // State and datapath registers
    always_ff @(posedge chip_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            layer_idx_q <= 6'd0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            done_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            layer_idx_q <= layer_idx_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        layer_idx_d = layer_idx_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        done_cnt_d  = done_cnt_q;

        case (state_q)
            S_IDLE: begin
                // start_layer has priority over a store in the same cycle.
                if (start_layer) begin
                    state_d = S_COMPUTE;
                    cnt_d   = lat_to_cnt(lat_tbl_q[layer_idx_q]);
                end else if (req_store) begin
                    state_d = S_COMPUTE;
                    cnt_d   = lat_to_cnt(LAT_W'(STORE_LAT));
                end
            end

            S_COMPUTE: begin
                // Requests while busy are flagged and dropped; cnt is untouched.
                if (start_layer || req_store) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    layer_idx_d = idx_next;
                    done_cnt_d  = done_cnt_q + 32'd1;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are driven straight from registers. There is no path from any
    // input to an output.
    always_comb begin
        busy        = (state_q == S_COMPUTE);
        done_layer  = done_q;
        layer_idx   = layer_idx_q;
        overrun_err = overrun_q;
        done_cnt    = done_cnt_q;
    end

endmodule

// File: doc/chip_layer_responder.md
# chip_layer_responder

Chip-side counterpart of the FPGA network controller: accepts `start_layer` pulses, emulates per-layer compute time from a programmable latency table, and returns a single-cycle `done_layer` pulse. Sits in the `chip_clk` domain in place of (or beside) the silicon, so the controller, host software and power-measure loops can be brought up and regressed without a chip.

## Interface
Parameters:
- `LAT_W`, 16, width of the per-layer latency value.
- `STORE_LAT`, 4, fixed latency in cycles for a `start_store_byte4` request (only used when `LOOPBACK_TEST_EN` is defined).

Ports:
- `chip_clk` in 1: single clock. All logic is on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start_layer` in 1: layer start request from the controller; single-cycle pulse.
- `start_store_byte4` in 1: store request from the controller; honoured only with `LOOPBACK_TEST_EN`.
- `n_layers` in 6: number of layers; sets the wrap point of `layer_idx`.
- `cfg_we` in 1: latency-table write enable.
- `cfg_addr` in 6: latency-table entry to write.
- `cfg_lat` in `LAT_W`: latency value to write.
- `done_layer` out 1: layer complete; single-cycle pulse.
- `busy` out 1: high while in `S_COMPUTE`.
- `layer_idx` out 6: index of the next layer to run.
- `overrun_err` out 1: sticky flag; set when a request arrives while busy.
- `done_cnt` out 32: total `done_layer` pulses since reset; wraps at 2^32.

## Operation
- Latency table: 64 × `LAT_W` flops, written when `cfg_we` is high. Writes are allowed in any state.
- States:
  - `S_IDLE`: waiting for a request.
  - `S_COMPUTE`: down-counter running.
  - On the final count, the block sets `done_layer` and returns directly to `S_IDLE`. There is no separate done state.
- IDLE→COMPUTE on `start_layer`:
  - Latch L = `table[layer_idx]`. L = 0 is treated as 1.
  - Load `cnt` with L−1.
- COMPUTE:
  - `cnt` decrements each cycle.
  - When `cnt` == 0: set `done_layer` for one cycle, update `layer_idx`, increment `done_cnt`, and go to IDLE.
- `layer_idx` update:
  - If `layer_idx` == `n_layers`−1, wrap to 0. Otherwise add 1.
  - If `n_layers` == 0, `layer_idx` stays 0.
  - `n_layers` is sampled live at the update edge.
- Overrun: a request sampled in COMPUTE sets `overrun_err`, is ignored, and does not disturb `cnt`. Only reset clears `overrun_err`.
- Reset values, asserted asynchronously at any time including mid-compute:
  - State `S_IDLE`; `done_layer`, `busy`, `overrun_err` = 0.
  - `layer_idx`, `done_cnt`, `cnt` = 0.
  - Every table entry = 1.

## Timing
- `start_layer` is sampled high at edge k in IDLE:
  - `busy` is high from edge k.
  - `done_layer` is high for exactly the cycle following edge k+L.
  - `busy` falls at edge k+L.
- Back-to-back:
  - A start sampled at edge k+L+1 (while `done_layer` is high) is accepted, because the state is already IDLE.
  - This matches the controller, which restarts one cycle after `done_layer`.
- Table write and start in the same edge, same entry: the load uses the old value. The new value applies to later starts.
- `done_layer`, `busy`, `layer_idx`, `done_cnt` and `overrun_err` are all registered; there are no combinational paths from inputs.

## Configuration
- Macro `LOOPBACK_TEST_EN`, **defined**:
  - `start_store_byte4` sampled in IDLE starts a compute with L = `STORE_LAT` instead of a table lookup.
  - Completion behaves exactly like a layer: `done_layer` pulse, `layer_idx` update, `done_cnt` increment.
  - If `start_layer` and `start_store_byte4` are high in the same cycle, `start_layer` wins and no overrun is flagged.
  - `start_store_byte4` sampled in COMPUTE sets `overrun_err`.
- Macro **not defined**: `start_store_byte4` is ignored in all states; the port remains present.

## Test plan
- Reset, write `table[0]`=5, pulse `start_layer` at edge 10 → `busy` is high for edges 10–14 and `done_layer` is high in the cycle after edge 15; `layer_idx`=1, `done_cnt`=1.
- `n_layers`=3, latencies {2,0,7}, controller-style restart one cycle after each done, 6 starts → `done_layer` gaps are 2, 1, 7, 2, 1, 7 cycles; `layer_idx` sequence is 1, 2, 0, 1, 2, 0; `done_cnt`=6.
- Second `start_layer` 2 cycles into a 10-cycle layer → `overrun_err`=1 and stays 1; the first `done_layer` still arrives at L=10; exactly one done is produced.
- Write `table[0]`=9 on the same edge as `start_layer` with the old value 3 → done arrives after 3 cycles; the next start on entry 0 takes 9 cycles.
- `rstn` dropped mid-compute → all outputs are 0 immediately and no `done_layer` appears afterwards; a fresh start after release behaves normally with table entries = 1.
- With `LOOPBACK_TEST_EN`, `STORE_LAT`=4: `start_store_byte4` pulse → `done_layer` after 4 cycles and `layer_idx` increments. Simultaneous `start_layer` + `start_store_byte4` → table latency is used and `overrun_err` stays 0. Without the macro: `start_store_byte4` alone → no `busy`, no `done_layer`.
